mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk input 1, pipeline clock; rst input 1, asynchronous active-low reset.
REQ-002 SHALL have inst_req input 1 (fetch request) and inst_addr input 32 (fetch address).
REQ-003 SHALL have inst_rdata output 32 (fetch data) and inst_ok output 1 (one-cycle completion pulse).
REQ-004 SHALL have data_req input 1, data_wen input 4 (byte write enables; 0 = load), data_addr input 32, data_wdata input 32.
REQ-005 SHALL have data_rdata output 32 and data_ok output 1 (one-cycle completion pulse).
REQ-006 SHALL have mem_en output 1, mem_wen output 4, mem_addr output 32, mem_wdata output 32 and mem_rdata input 32, driving one synchronous single-port SRAM with 1-cycle read latency.
REQ-007 SHALL have stall_inst output 1 = inst_req & ~inst_ok, and stall_data output 1 = data_req & ~data_ok, both for the hazard unit.

Function
REQ-008 Requester handshake: req, addr, wen and wdata held stable from request until its ok pulse; req is dropped or re-presented with a new request in the cycle after ok.
REQ-009 FSM states: IDLE, INST_WAIT, DATA_WAIT.
REQ-010 Issue cycle: mem_en=1, and mem_addr, mem_wen, mem_wdata are taken from the granted requester; mem_wen=0 for inst grants.
REQ-011 FSM moves to INST_WAIT or DATA_WAIT per grant; with no grant it goes to or stays in IDLE with mem_en=0, mem_wen=0.
REQ-012 In x_WAIT the arbiter pulses x_ok=1 for exactly one cycle, so latency is request-issue +1 cycle (2 cycles minimum from req rise in IDLE).
REQ-013 In the ok cycle, x_rdata = mem_rdata combinationally and a hold register captures it; x_rdata shows the held value at all other times.
REQ-014 Writes (data_wen != 0) commit in the issue cycle; data_ok still pulses next cycle; data_rdata hold register is not updated.
REQ-015 Back-to-back: in an x_WAIT cycle the arbiter issues the next request in the same cycle; the requester just served is ineligible that cycle, so throughput is 1 access/cycle when both alternate.
REQ-016 Arbitration when both are eligible: round-robin on the last_grant register; data wins when last_grant=inst or after reset.
REQ-017 When only one requester is eligible it is granted regardless of last_grant.
REQ-018 last_grant SHALL update only on an issue cycle.
REQ-019 inst_ok and data_ok never both 1; mem_en never 1 without a grant.
REQ-020 Addresses pass through unmodified; alignment checks belong to the requester.

Reset
REQ-021 rst=0 asynchronously forces IDLE, last_grant=inst, inst_ok=0, data_ok=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0, and both rdata hold registers to 0.
REQ-022 Reset mid-access abandons the outstanding access with no ok pulse; the first grant after release follows REQ-016.

Structure
REQ-023 State encoding (IDLE=2'd0, INST_WAIT=2'd1, DATA_WAIT=2'd2) and grant IDs SHALL live in a shared package mem_arb_pkg.
REQ-024 The 2-way round-robin grant logic SHALL be one sub-module arb2_rr: inputs req[1:0], last; output gnt[1:0].
REQ-025 The remainder SHALL be flat RTL: FSM, issue mux, hold registers.

Verification
REQ-026 Inst only: inst_req=1, inst_addr=0xBFC00000, SRAM word 0x3C088000 -> mem_en at cycle 0, inst_ok=1 with inst_rdata=0x3C088000 at cycle 1, stall_inst=0 at cycle 1.
REQ-027 Simultaneous after reset: inst_req=data_req=1, data_addr=0x80000010 -> data issued first, data_ok at cycle 1 with inst issued that same cycle, inst_ok at cycle 2.
REQ-028 Store: data_wen=4'b0011, data_addr=0x100, data_wdata=0xAABBCCDD, then load 0x100 -> data_ok both times; load returns low half 0xCCDD and upper bytes retain their prior value.
REQ-029 Continuous both-requesting for 10 cycles -> grants alternate D,I,D,I..., one ok per cycle after the first, no ok overlap.
REQ-030 rst asserted during DATA_WAIT -> no data_ok, mem_en=0 immediately, held rdata=0; after release a pending inst_req completes in 2 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states and
// grant identifiers. A grant ID doubles as its bit index in req/gnt vectors.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_WAIT = 2'd1,
        DATA_WAIT = 2'd2
    } arb_state_t;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and SRAM signal bundle for mem_arbiter. The master modport is the
// arbiter's view; the slave modport is the requesters plus the SRAM.
interface mem_arbiter_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;

    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;

    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stall_inst;
    logic        stall_data;

    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_wen, data_addr, data_wdata,
        input  mem_rdata,
        output inst_rdata, inst_ok, data_rdata, data_ok,
        output mem_en, mem_wen, mem_addr, mem_wdata,
        output stall_inst, stall_data
    );

    modport slave (
        output inst_req, inst_addr,
        output data_req, data_wen, data_addr, data_wdata,
        output mem_rdata,
        input  inst_rdata, inst_ok, data_rdata, data_ok,
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        input  stall_inst, stall_data
    );

endinterface

// File: rtl/mem_arbiter_arb2_rr.sv
// Two-way round-robin grant: with both requesting, the side not granted last
// wins; a lone requester always wins.
module arb2_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[GNT_DATA] && (!req[GNT_INST] || (last == GNT_INST))) begin
            gnt[GNT_DATA] = 1'b1;
        end else if (req[GNT_INST]) begin
            gnt[GNT_INST] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port SRAM with
// 1-cycle read latency; the next access issues in the same cycle as an ok.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    logic        r_last_grant;
    logic        r_data_is_wr;
    logic [31:0] r_inst_hold;
    logic [31:0] r_data_hold;

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_issue;
    logic        w_inst_ok;
    logic        w_data_ok;

    // The requester being served this cycle cannot be re-granted until it has seen its ok.
    assign w_req[GNT_INST] = bus.inst_req & (r_state != INST_WAIT);
    assign w_req[GNT_DATA] = bus.data_req & (r_state != DATA_WAIT);

    arb2_rr u_arb (
        .req  (w_req),
        .last (r_last_grant),
        .gnt  (w_gnt)
    );

    assign w_issue   = rst & (|w_gnt);
    assign w_inst_ok = (r_state == INST_WAIT);
    assign w_data_ok = (r_state == DATA_WAIT);

    assign bus.inst_ok    = w_inst_ok;
    assign bus.data_ok    = w_data_ok;
    assign bus.inst_rdata = w_inst_ok ? bus.mem_rdata : r_inst_hold;
    assign bus.data_rdata = (w_data_ok && !r_data_is_wr) ? bus.mem_rdata : r_data_hold;
    assign bus.stall_inst = bus.inst_req & ~w_inst_ok;
    assign bus.stall_data = bus.data_req & ~w_data_ok;

    always_comb begin
        w_state_next  = IDLE;
        bus.mem_en    = 1'b0;
        bus.mem_wen   = 4'b0000;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        if (w_issue) begin
            bus.mem_en = 1'b1;
            if (w_gnt[GNT_DATA]) begin
                w_state_next  = DATA_WAIT;
                bus.mem_wen   = bus.data_wen;
                bus.mem_addr  = bus.data_addr;
                bus.mem_wdata = bus.data_wdata;
            end else begin
                w_state_next  = INST_WAIT;
                bus.mem_addr  = bus.inst_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_INST;
            r_data_is_wr <= 1'b0;
            r_inst_hold  <= 32'h0;
            r_data_hold  <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_last_grant <= w_gnt[GNT_DATA] ? GNT_DATA : GNT_INST;
                r_data_is_wr <= w_gnt[GNT_DATA] & (|bus.data_wen);
            end
            if (w_inst_ok) begin
                r_inst_hold <= bus.mem_rdata;
            end
            if (w_data_ok && !r_data_is_wr) begin
                r_data_hold <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two requester engines fed from to-do queues,
// a scoreboard of expected read data, and a behavioural byte-enabled SRAM.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] exp;
    } req_t;

    req_t inst_todo[$];
    req_t data_todo[$];
    req_t inst_sb[$];
    req_t data_sb[$];
    logic inst_active;
    logic data_active;

    int errors = 0;
    int checks = 0;

    logic        o_mem_en, o_inst_ok, o_data_ok, o_stall_inst;
    logic [3:0]  o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wdata, o_inst_rdata, o_data_rdata;

    // Synchronous SRAM: read-before-write, 1-cycle read latency.
    logic [31:0] sram [logic [29:0]];
    logic [31:0] sram_cur;
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            sram_cur = sram.exists(bus.mem_addr[31:2]) ? sram[bus.mem_addr[31:2]] : 32'h0;
            bus.mem_rdata <= sram_cur;
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wen[b]) sram_cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            end
            sram[bus.mem_addr[31:2]] = sram_cur;
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        sram[addr[31:2]] = val;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic kick();
        req_t r;
        if (!inst_active && inst_todo.size() > 0) begin
            r = inst_todo.pop_front();
            bus.inst_req  = 1'b1;
            bus.inst_addr = r.addr;
            inst_sb.push_back(r);
            inst_active = 1'b1;
        end
        if (!data_active && data_todo.size() > 0) begin
            r = data_todo.pop_front();
            bus.data_req   = 1'b1;
            bus.data_addr  = r.addr;
            bus.data_wen   = r.wen;
            bus.data_wdata = r.wdata;
            data_sb.push_back(r);
            data_active = 1'b1;
        end
    endtask

    // Observe one cycle at the falling edge, then advance requesters after the rising edge.
    task automatic tick();
        logic i_done, d_done;
        req_t r;
        @(negedge clk);
        o_mem_en     = bus.mem_en;
        o_mem_wen    = bus.mem_wen;
        o_mem_addr   = bus.mem_addr;
        o_mem_wdata  = bus.mem_wdata;
        o_inst_ok    = bus.inst_ok;
        o_data_ok    = bus.data_ok;
        o_inst_rdata = bus.inst_rdata;
        o_data_rdata = bus.data_rdata;
        o_stall_inst = bus.stall_inst;
        i_done = (bus.inst_ok === 1'b1);
        d_done = (bus.data_ok === 1'b1);
        chk1("ok_exclusive", bus.inst_ok & bus.data_ok, 1'b0);
        if (i_done) begin
            if (inst_sb.size() == 0) begin
                chk1("inst_ok_spurious", bus.inst_ok, 1'b0);
            end else begin
                r = inst_sb.pop_front();
                chk("sb_inst_rdata", bus.inst_rdata, r.exp);
                $display("txn inst addr=%h rdata=%h", r.addr, bus.inst_rdata);
            end
        end
        if (d_done) begin
            if (data_sb.size() == 0) begin
                chk1("data_ok_spurious", bus.data_ok, 1'b0);
            end else begin
                r = data_sb.pop_front();
                if (r.wen == 4'b0000) chk("sb_data_rdata", bus.data_rdata, r.exp);
                $display("txn data addr=%h wen=%b rdata=%h", r.addr, r.wen, bus.data_rdata);
            end
        end
        @(posedge clk);
        #1;
        if (i_done && inst_active) begin
            inst_active  = 1'b0;
            bus.inst_req = 1'b0;
        end
        if (d_done && data_active) begin
            data_active  = 1'b0;
            bus.data_req = 1'b0;
        end
        kick();
    endtask

    task automatic drained(input string tag);
        chk({tag, "_inst_sb"}, 32'(inst_sb.size()), 32'd0);
        chk({tag, "_data_sb"}, 32'(data_sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        inst_active = 1'b0;
        data_active = 1'b0;
        inst_todo.delete(); data_todo.delete();
        inst_sb.delete();   data_sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        inst_active = 1'b0;
        data_active = 1'b0;
        // Requests held high during reset must not reach the SRAM.
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'h0000_0040;
        bus.data_req   = 1'b1;
        bus.data_wen   = 4'hF;
        bus.data_addr  = 32'h0000_0080;
        bus.data_wdata = 32'h5555_AAAA;

        @(negedge clk);
        chk1("rst_mem_en",    bus.mem_en, 1'b0);
        chk("rst_mem_wen",    32'(bus.mem_wen), 32'd0);
        chk("rst_mem_addr",   bus.mem_addr, 32'h0);
        chk("rst_mem_wdata",  bus.mem_wdata, 32'h0);
        chk1("rst_inst_ok",   bus.inst_ok, 1'b0);
        chk1("rst_data_ok",   bus.data_ok, 1'b0);
        chk("rst_inst_rdata", bus.inst_rdata, 32'h0);
        chk("rst_data_rdata", bus.data_rdata, 32'h0);
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        bus.data_wen = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Instruction fetch alone.
        preload(32'hBFC0_0000, 32'h3C08_8000);
        inst_todo.push_back('{32'hBFC0_0000, 4'h0, 32'h0, 32'h3C08_8000});
        kick();
        tick();
        chk1("t1_c0_mem_en",  o_mem_en, 1'b1);
        chk("t1_c0_mem_addr", o_mem_addr, 32'hBFC0_0000);
        chk1("t1_c0_inst_ok", o_inst_ok, 1'b0);
        tick();
        chk1("t1_c1_inst_ok",    o_inst_ok, 1'b1);
        chk1("t1_c1_stall_inst", o_stall_inst, 1'b0);
        chk("t1_c1_inst_rdata",  o_inst_rdata, 32'h3C08_8000);
        tick();
        chk1("t1_c2_mem_en",    o_mem_en, 1'b0);
        chk1("t1_c2_inst_ok",   o_inst_ok, 1'b0);
        chk("t1_c2_inst_hold",  o_inst_rdata, 32'h3C08_8000);
        drained("t1");

        // Simultaneous requests straight after reset: data first.
        do_reset();
        preload(32'h8000_0010, 32'hDEAD_BEEF);
        preload(32'hBFC0_0004, 32'h1234_5678);
        inst_todo.push_back('{32'hBFC0_0004, 4'h0, 32'h0, 32'h1234_5678});
        data_todo.push_back('{32'h8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF});
        kick();
        tick();
        chk1("t2_c0_mem_en",  o_mem_en, 1'b1);
        chk("t2_c0_mem_addr", o_mem_addr, 32'h8000_0010);
        tick();
        chk1("t2_c1_data_ok", o_data_ok, 1'b1);
        chk1("t2_c1_inst_ok", o_inst_ok, 1'b0);
        chk1("t2_c1_mem_en",  o_mem_en, 1'b1);
        chk("t2_c1_mem_addr", o_mem_addr, 32'hBFC0_0004);
        tick();
        chk1("t2_c2_inst_ok", o_inst_ok, 1'b1);
        chk1("t2_c2_data_ok", o_data_ok, 1'b0);
        tick();
        drained("t2");

        // Half-word store then load of the same word.
        preload(32'h0000_0100, 32'h1122_3344);
        data_todo.push_back('{32'h0000_0100, 4'b0011, 32'hAABB_CCDD, 32'h0});
        data_todo.push_back('{32'h0000_0100, 4'b0000, 32'h0, 32'h1122_CCDD});
        kick();
        tick();
        chk("t3_c0_mem_wen",   32'(o_mem_wen), 32'h3);
        chk("t3_c0_mem_wdata", o_mem_wdata, 32'hAABB_CCDD);
        chk("t3_c0_mem_addr",  o_mem_addr, 32'h0000_0100);
        tick();
        chk1("t3_c1_data_ok",  o_data_ok, 1'b1);
        tick();
        chk1("t3_c2_mem_en",   o_mem_en, 1'b1);
        chk("t3_c2_mem_wen",   32'(o_mem_wen), 32'h0);
        chk("t3_c2_hold_kept", o_data_rdata, 32'hDEAD_BEEF);
        tick();
        chk1("t3_c3_data_ok",  o_data_ok, 1'b1);
        chk("t3_c3_load",      o_data_rdata, 32'h1122_CCDD);
        tick();
        drained("t3");

        // Both requesting continuously: D,I,D,I... one ok per cycle.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            preload(32'h0000_0200 + 32'(4*k), 32'hD000_0000 + 32'(k));
            preload(32'h0000_0300 + 32'(4*k), 32'h1000_0000 + 32'(k));
            data_todo.push_back('{32'h0000_0200 + 32'(4*k), 4'h0, 32'h0, 32'hD000_0000 + 32'(k)});
            inst_todo.push_back('{32'h0000_0300 + 32'(4*k), 4'h0, 32'h0, 32'h1000_0000 + 32'(k)});
        end
        kick();
        for (int c = 0; c <= 10; c++) begin
            tick();
            if (c < 10) begin
                chk1("t4_mem_en", o_mem_en, 1'b1);
                chk1("t4_grant_is_inst", o_mem_addr[8], (c % 2) == 1);
            end
            if (c >= 1) chk1("t4_one_ok", o_inst_ok ^ o_data_ok, 1'b1);
        end
        tick();
        chk1("t4_tail_inst_ok", o_inst_ok, 1'b0);
        chk1("t4_tail_data_ok", o_data_ok, 1'b0);
        drained("t4");

        // Reset during DATA_WAIT abandons the load; pending fetch then completes.
        preload(32'h0000_0400, 32'hCAFE_F00D);
        preload(32'hBFC0_0008, 32'h0BAD_C0DE);
        data_todo.push_back('{32'h0000_0400, 4'h0, 32'h0, 32'hCAFE_F00D});
        kick();
        tick();
        chk1("t5_c0_mem_en",  o_mem_en, 1'b1);
        chk("t5_c0_mem_addr", o_mem_addr, 32'h0000_0400);
        rst = 1'b0;
        bus.data_req = 1'b0;
        data_active  = 1'b0;
        data_sb.delete();
        inst_todo.push_back('{32'hBFC0_0008, 4'h0, 32'h0, 32'h0BAD_C0DE});
        kick();
        tick();
        chk1("t5_rst_data_ok",   o_data_ok, 1'b0);
        chk1("t5_rst_mem_en",    o_mem_en, 1'b0);
        chk("t5_rst_data_rdata", o_data_rdata, 32'h0);
        chk("t5_rst_inst_rdata", o_inst_rdata, 32'h0);
        rst = 1'b1;
        tick();
        chk1("t5_r0_mem_en",  o_mem_en, 1'b1);
        chk("t5_r0_mem_addr", o_mem_addr, 32'hBFC0_0008);
        tick();
        chk1("t5_r1_inst_ok", o_inst_ok, 1'b1);
        chk("t5_r1_rdata",    o_inst_rdata, 32'h0BAD_C0DE);
        tick();
        drained("t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
